// File: rtl/ctrl_path_arbiter_pkg.sv
// Shared control-path definitions: arbiter FSM encoding, abort-beat fill and
// the round-robin pick used when both sources may be requesting.
package ctrl_path_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FWD  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // Abort beat closes a stalled packet with an empty payload.
   localparam logic ABORT_TLAST = 1'b1;
   localparam logic ABORT_FILL  = 1'b0;

   // Returns the granted source index: the preferred one if valid, else the other.
   function automatic logic rr_pick(input logic rr_ptr, input logic v0, input logic v1);
      if (rr_ptr) return v1 ? 1'b1 : 1'b0;
      else        return v0 ? 1'b0 : 1'b1;
   endfunction

endpackage

// File: rtl/ctrl_path_arbiter.sv
// Packet-atomic round-robin merge of two control AXI-Stream sources onto the
// stage-chain control input, with a post-packet guard gap and stall abort.
module ctrl_path_arbiter
   import ctrl_path_arbiter_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 512,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int GAP_CYCLES           = 4,
   parameter int STALL_TIMEOUT        = 64,
   parameter int CNT_WIDTH            = 16
) (
   input  logic                              axis_clk,
   input  logic                              reset,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
   input  logic                              s0_axis_tvalid,
   input  logic                              s0_axis_tlast,
   output logic                              s0_axis_tready,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
   input  logic                              s1_axis_tvalid,
   input  logic                              s1_axis_tlast,
   output logic                              s1_axis_tready,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
   output logic                              c_m_axis_tvalid,
   output logic                              c_m_axis_tlast,

   output logic                              busy,
   output logic [CNT_WIDTH-1:0]              abort_cnt
);

   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int TW = C_S_AXIS_TUSER_WIDTH;
   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
   // stall_cnt only has to hold up to STALL_TIMEOUT-1
   localparam int SW = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT);
   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

   logic [1:0]    state;
   logic          grant;
   logic          rr_ptr;
   logic [SW-1:0] stall_cnt;
   logic [GW-1:0] gap_cnt;

   logic          sel_valid;
   logic          sel_last;
   logic [DW-1:0] sel_data;
   logic [TW-1:0] sel_user;
   logic [KW-1:0] sel_keep;
   logic          fwd;

   assign fwd       = (state == ST_FWD);
   assign sel_valid = grant ? s1_axis_tvalid : s0_axis_tvalid;
   assign sel_last  = grant ? s1_axis_tlast  : s0_axis_tlast;
   assign sel_data  = grant ? s1_axis_tdata  : s0_axis_tdata;
   assign sel_user  = grant ? s1_axis_tuser  : s0_axis_tuser;
   assign sel_keep  = grant ? s1_axis_tkeep  : s0_axis_tkeep;

   // tready depends on state only, so the chain never sees a combinational path
   assign s0_axis_tready = fwd & ~grant;
   assign s1_axis_tready = fwd &  grant;
   assign busy           = (state != ST_IDLE);

   always_ff @(posedge axis_clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         grant           <= 1'b0;
         rr_ptr          <= 1'b0;
         stall_cnt       <= '0;
         gap_cnt         <= '0;
         abort_cnt       <= '0;
         c_m_axis_tvalid <= 1'b0;
         c_m_axis_tlast  <= 1'b0;
         c_m_axis_tdata  <= '0;
         c_m_axis_tuser  <= '0;
         c_m_axis_tkeep  <= '0;
      end else begin
         c_m_axis_tvalid <= 1'b0;
         c_m_axis_tlast  <= 1'b0;
         c_m_axis_tdata  <= '0;
         c_m_axis_tuser  <= '0;
         c_m_axis_tkeep  <= '0;

         case (state)
            ST_IDLE: begin
               stall_cnt <= '0;
               if (s0_axis_tvalid | s1_axis_tvalid) begin
                  grant <= rr_pick(rr_ptr, s0_axis_tvalid, s1_axis_tvalid);
                  state <= ST_FWD;
               end
            end

            ST_FWD: begin
               if (sel_valid) begin
                  c_m_axis_tvalid <= 1'b1;
                  c_m_axis_tlast  <= sel_last;
                  c_m_axis_tdata  <= sel_data;
                  c_m_axis_tuser  <= sel_user;
                  c_m_axis_tkeep  <= sel_keep;
                  stall_cnt       <= '0;
                  if (sel_last) begin
                     rr_ptr <= ~grant;
                     if (GAP_CYCLES == 0) state <= ST_IDLE;
                     else begin
                        state   <= ST_GAP;
                        gap_cnt <= GW'(GAP_CYCLES);
                     end
                  end
               end else if (stall_cnt == SW'(STALL_TIMEOUT - 1)) begin
                  // this is the STALL_TIMEOUT-th idle cycle: close the packet
                  c_m_axis_tvalid <= 1'b1;
                  c_m_axis_tlast  <= ABORT_TLAST;
                  c_m_axis_tdata  <= {DW{ABORT_FILL}};
                  c_m_axis_tuser  <= {TW{ABORT_FILL}};
                  c_m_axis_tkeep  <= {KW{ABORT_FILL}};
                  stall_cnt       <= '0;
                  rr_ptr          <= ~grant;
                  if (abort_cnt != {CNT_WIDTH{1'b1}}) abort_cnt <= abort_cnt + 1'b1;
                  if (GAP_CYCLES == 0) state <= ST_IDLE;
                  else begin
                     state   <= ST_GAP;
                     gap_cnt <= GW'(GAP_CYCLES);
                  end
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end

            ST_GAP: begin
               if (gap_cnt <= GW'(1)) state <= ST_IDLE;
               else                   gap_cnt <= gap_cnt - 1'b1;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_path_arbiter.sv
// Directed bench for ctrl_path_arbiter: cycle tables for the main flows plus
// hand sequences for fairness, stall abort, mid-packet reset and zero gap.
module tb_ctrl_path_arbiter;

   localparam int DW = 32;
   localparam int TW = 8;
   localparam int KW = 4;

   logic axis_clk = 1'b0;
   always #5 axis_clk = ~axis_clk;

   logic reset = 1'b1;

   logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
   logic [TW-1:0] s0_tuser = '0, s1_tuser = '0;
   logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0;
   logic          s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0;
   logic          s0_tready, s1_tready;
   logic [DW-1:0] m_tdata;
   logic [TW-1:0] m_tuser;
   logic [KW-1:0] m_tkeep;
   logic          m_tvalid, m_tlast, busy;
   logic [15:0]   abort_cnt;

   // second instance with no guard gap
   logic [DW-1:0] z0_tdata = '0, z1_tdata = '0;
   logic [TW-1:0] z0_tuser = '0, z1_tuser = '0;
   logic [KW-1:0] z0_tkeep = '0, z1_tkeep = '0;
   logic          z0_tvalid = 1'b0, z0_tlast = 1'b0, z1_tvalid = 1'b0, z1_tlast = 1'b0;
   logic          z0_tready, z1_tready;
   logic [DW-1:0] zm_tdata;
   logic [TW-1:0] zm_tuser;
   logic [KW-1:0] zm_tkeep;
   logic          zm_tvalid, zm_tlast, z_busy;
   logic [15:0]   z_abort_cnt;

   ctrl_path_arbiter #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(TW),
      .GAP_CYCLES(4), .STALL_TIMEOUT(64), .CNT_WIDTH(16)) dut (
      .axis_clk(axis_clk), .reset(reset),
      .s0_axis_tdata(s0_tdata), .s0_axis_tuser(s0_tuser), .s0_axis_tkeep(s0_tkeep),
      .s0_axis_tvalid(s0_tvalid), .s0_axis_tlast(s0_tlast), .s0_axis_tready(s0_tready),
      .s1_axis_tdata(s1_tdata), .s1_axis_tuser(s1_tuser), .s1_axis_tkeep(s1_tkeep),
      .s1_axis_tvalid(s1_tvalid), .s1_axis_tlast(s1_tlast), .s1_axis_tready(s1_tready),
      .c_m_axis_tdata(m_tdata), .c_m_axis_tuser(m_tuser), .c_m_axis_tkeep(m_tkeep),
      .c_m_axis_tvalid(m_tvalid), .c_m_axis_tlast(m_tlast),
      .busy(busy), .abort_cnt(abort_cnt));

   ctrl_path_arbiter #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(TW),
      .GAP_CYCLES(0), .STALL_TIMEOUT(64), .CNT_WIDTH(16)) dut_z (
      .axis_clk(axis_clk), .reset(reset),
      .s0_axis_tdata(z0_tdata), .s0_axis_tuser(z0_tuser), .s0_axis_tkeep(z0_tkeep),
      .s0_axis_tvalid(z0_tvalid), .s0_axis_tlast(z0_tlast), .s0_axis_tready(z0_tready),
      .s1_axis_tdata(z1_tdata), .s1_axis_tuser(z1_tuser), .s1_axis_tkeep(z1_tkeep),
      .s1_axis_tvalid(z1_tvalid), .s1_axis_tlast(z1_tlast), .s1_axis_tready(z1_tready),
      .c_m_axis_tdata(zm_tdata), .c_m_axis_tuser(zm_tuser), .c_m_axis_tkeep(zm_tkeep),
      .c_m_axis_tvalid(zm_tvalid), .c_m_axis_tlast(zm_tlast),
      .busy(z_busy), .abort_cnt(z_abort_cnt));

   typedef struct {
      string         nm;
      logic          v0; logic [DW-1:0] d0; logic l0;
      logic          v1; logic [DW-1:0] d1; logic l1;
      logic          ev; logic [DW-1:0] ed; logic el;
      logic          er0; logic er1; logic eb;
   } vec_t;

   typedef struct {
      int cyc; logic [DW-1:0] d; logic [TW-1:0] u; logic [KW-1:0] k; logic l;
   } ev_t;

   int total = 0;
   int bad   = 0;

   vec_t tbl1[$];
   vec_t tbl3[$];
   ev_t  evq[$];
   logic [DW-1:0] got[$];
   logic          gotl[$];
   logic [DW-1:0] p0[4];
   logic [DW-1:0] p1[4];
   logic [DW-1:0] exp2[8];
   int   i0, i1, first_r1, zcyc[$];
   logic f0, f1, both_hi, s1_done, zb[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic drv0(input logic v, input logic [DW-1:0] d, input logic l);
      s0_tvalid = v; s0_tdata = v ? d : '0; s0_tuser = v ? d[7:0] : '0;
      s0_tkeep = v ? '1 : '0; s0_tlast = v & l;
   endtask

   task automatic drv1(input logic v, input logic [DW-1:0] d, input logic l);
      s1_tvalid = v; s1_tdata = v ? d : '0; s1_tuser = v ? d[7:0] : '0;
      s1_tkeep = v ? '1 : '0; s1_tlast = v & l;
   endtask

   task automatic drvz(input logic v, input logic [DW-1:0] d, input logic l);
      z0_tvalid = v; z0_tdata = v ? d : '0; z0_tuser = v ? d[7:0] : '0;
      z0_tkeep = v ? '1 : '0; z0_tlast = v & l;
   endtask

   task automatic next_cyc();
      @(posedge axis_clk); #1;
   endtask

   function automatic vec_t mk(input string nm,
      input logic v0, input logic [DW-1:0] d0, input logic l0,
      input logic v1, input logic [DW-1:0] d1, input logic l1,
      input logic ev, input logic [DW-1:0] ed, input logic el,
      input logic er0, input logic er1, input logic eb);
      vec_t v;
      v.nm = nm; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1;
      v.ev = ev; v.ed = ed; v.el = el; v.er0 = er0; v.er1 = er1; v.eb = eb;
      return v;
   endfunction

   // inputs are driven just after the edge, outputs sampled on the falling edge
   task automatic apply(input vec_t v);
      drv0(v.v0, v.d0, v.l0);
      drv1(v.v1, v.d1, v.l1);
      @(negedge axis_clk);
      chk({v.nm, ".tvalid"}, 64'(m_tvalid), 64'(v.ev));
      chk({v.nm, ".tdata"},  64'(m_tdata),  v.ev ? 64'(v.ed) : 64'd0);
      chk({v.nm, ".tuser"},  64'(m_tuser),  v.ev ? 64'(v.ed[7:0]) : 64'd0);
      chk({v.nm, ".tkeep"},  64'(m_tkeep),  v.ev ? 64'hF : 64'd0);
      chk({v.nm, ".tlast"},  64'(m_tlast),  64'(v.ev & v.el));
      chk({v.nm, ".tready0"}, 64'(s0_tready), 64'(v.er0));
      chk({v.nm, ".tready1"}, 64'(s1_tready), 64'(v.er1));
      chk({v.nm, ".busy"},   64'(busy),     64'(v.eb));
      next_cyc();
   endtask

   task automatic do_reset(input string nm);
      drv0(1'b0, '0, 1'b0); drv1(1'b0, '0, 1'b0); drvz(1'b0, '0, 1'b0);
      reset = 1'b1;
      next_cyc();
      @(negedge axis_clk);
      chk({nm, ".tvalid"}, 64'(m_tvalid), 64'd0);
      chk({nm, ".tready"}, 64'({s0_tready, s1_tready}), 64'd0);
      chk({nm, ".busy"}, 64'(busy), 64'd0);
      chk({nm, ".abort_cnt"}, 64'(abort_cnt), 64'd0);
      next_cyc();
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      drv0(1'b0, '0, 1'b0); drv1(1'b0, '0, 1'b0);
      repeat (n) next_cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      // test 1: 3-beat s0 packet, GAP 4; second packet only granted after the gap
      tbl1.push_back(mk("t1c0", 1, 32'hA1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl1.push_back(mk("t1c1", 1, 32'hA1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      tbl1.push_back(mk("t1c2", 1, 32'hA2, 0, 0, 0, 0, 1, 32'hA1, 0, 1, 0, 1));
      tbl1.push_back(mk("t1c3", 1, 32'hA3, 1, 0, 0, 0, 1, 32'hA2, 0, 1, 0, 1));
      tbl1.push_back(mk("t1c4", 1, 32'hA4, 1, 0, 0, 0, 1, 32'hA3, 1, 0, 0, 1));
      tbl1.push_back(mk("t1c5", 1, 32'hA4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl1.push_back(mk("t1c6", 1, 32'hA4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl1.push_back(mk("t1c7", 1, 32'hA4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl1.push_back(mk("t1c8", 1, 32'hA4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl1.push_back(mk("t1c9", 1, 32'hA4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      tbl1.push_back(mk("t1c10", 0, 0, 0, 0, 0, 0, 1, 32'hA4, 1, 0, 0, 1));

      // test 3: lone s1 request with rr_ptr=0, then both request -> s0, then s1
      tbl3.push_back(mk("t3c0", 0, 0, 0, 1, 32'hB1, 1, 0, 0, 0, 0, 0, 0));
      tbl3.push_back(mk("t3c1", 0, 0, 0, 1, 32'hB1, 1, 0, 0, 0, 0, 1, 1));
      tbl3.push_back(mk("t3c2", 1, 32'hC1, 1, 1, 32'hD1, 1, 1, 32'hB1, 1, 0, 0, 1));
      tbl3.push_back(mk("t3c3", 1, 32'hC1, 1, 1, 32'hD1, 1, 0, 0, 0, 0, 0, 1));
      tbl3.push_back(mk("t3c4", 1, 32'hC1, 1, 1, 32'hD1, 1, 0, 0, 0, 0, 0, 1));
      tbl3.push_back(mk("t3c5", 1, 32'hC1, 1, 1, 32'hD1, 1, 0, 0, 0, 0, 0, 1));
      tbl3.push_back(mk("t3c6", 1, 32'hC1, 1, 1, 32'hD1, 1, 0, 0, 0, 0, 0, 0));
      tbl3.push_back(mk("t3c7", 1, 32'hC1, 1, 1, 32'hD1, 1, 0, 0, 0, 1, 0, 1));
      tbl3.push_back(mk("t3c8", 0, 0, 0, 1, 32'hD1, 1, 1, 32'hC1, 1, 0, 0, 1));
      tbl3.push_back(mk("t3c9", 0, 0, 0, 1, 32'hD1, 1, 0, 0, 0, 0, 0, 1));
      tbl3.push_back(mk("t3c10", 0, 0, 0, 1, 32'hD1, 1, 0, 0, 0, 0, 0, 1));
      tbl3.push_back(mk("t3c11", 0, 0, 0, 1, 32'hD1, 1, 0, 0, 0, 0, 0, 1));
      tbl3.push_back(mk("t3c12", 0, 0, 0, 1, 32'hD1, 1, 0, 0, 0, 0, 0, 0));
      tbl3.push_back(mk("t3c13", 0, 0, 0, 1, 32'hD1, 1, 0, 0, 0, 0, 1, 1));
      tbl3.push_back(mk("t3c14", 0, 0, 0, 0, 0, 0, 1, 32'hD1, 1, 0, 0, 1));

      next_cyc();
      do_reset("rst0");
      foreach (tbl1[k]) apply(tbl1[k]);
      idle(6);

      do_reset("rst1");
      foreach (tbl3[k]) apply(tbl3[k]);
      idle(6);

      // test 2: both sources hold 2-beat packets back to back
      do_reset("rst2");
      p0 = '{32'h10, 32'h11, 32'h12, 32'h13};
      p1 = '{32'h20, 32'h21, 32'h22, 32'h23};
      exp2 = '{32'h10, 32'h11, 32'h20, 32'h21, 32'h12, 32'h13, 32'h22, 32'h23};
      i0 = 0; i1 = 0; both_hi = 1'b0;
      for (int c = 0; c < 150 && got.size() < 8; c++) begin
         drv0(i0 < 4, p0[i0 & 3], (i0 % 2) == 1);
         drv1(i1 < 4, p1[i1 & 3], (i1 % 2) == 1);
         @(negedge axis_clk);
         if (s0_tready && s1_tready) both_hi = 1'b1;
         if (m_tvalid) begin
            got.push_back(m_tdata);
            gotl.push_back(m_tlast);
         end
         f0 = s0_tvalid & s0_tready;
         f1 = s1_tvalid & s1_tready;
         next_cyc();
         if (f0) i0++;
         if (f1) i1++;
      end
      chk("t2.count", 64'(got.size()), 64'd8);
      chk("t2.both_tready", 64'(both_hi), 64'd0);
      for (int k = 0; k < got.size() && k < 8; k++) begin
         chk($sformatf("t2.beat%0d", k), 64'(got[k]), 64'(exp2[k]));
         chk($sformatf("t2.last%0d", k), 64'(gotl[k]), 64'(k % 2));
      end
      idle(6);

      // test 4: one beat then a 64-cycle stall on s0; s1 queued behind it
      do_reset("rst4");
      s1_done = 1'b0; first_r1 = -1;
      for (int c = 0; c < 90; c++) begin
         drv0(c < 2, 32'hE1, 1'b0);
         drv1(c >= 10 && !s1_done, 32'hF1, 1'b1);
         @(negedge axis_clk);
         if (m_tvalid) evq.push_back('{c, m_tdata, m_tuser, m_tkeep, m_tlast});
         if (s1_tready && first_r1 < 0) first_r1 = c;
         f1 = s1_tvalid & s1_tready;
         next_cyc();
         if (f1) s1_done = 1'b1;
      end
      chk("t4.events", 64'(evq.size()), 64'd3);
      if (evq.size() == 3) begin
         chk("t4.beat.cyc",  64'(evq[0].cyc), 64'd2);
         chk("t4.beat.data", 64'(evq[0].d),   64'hE1);
         chk("t4.beat.last", 64'(evq[0].l),   64'd0);
         chk("t4.abort.cyc", 64'(evq[1].cyc), 64'd66);
         chk("t4.abort.beat", 64'({evq[1].d, evq[1].u, evq[1].k, evq[1].l}), 64'd1);
         chk("t4.s1.cyc",    64'(evq[2].cyc), 64'd72);
         chk("t4.s1.data",   64'(evq[2].d),   64'hF1);
         chk("t4.s1.keep",   64'(evq[2].k),   64'hF);
      end
      chk("t4.s1_first_ready", 64'(first_r1), 64'd71);
      chk("t4.abort_cnt", 64'(abort_cnt), 64'd1);

      // test 5: reset lands while beat 2 of a 4-beat packet is being accepted
      drv0(1'b1, 32'h61, 1'b0); next_cyc();           // IDLE grant
      drv0(1'b1, 32'h61, 1'b0); next_cyc();           // beat 1 accepted
      drv0(1'b1, 32'h62, 1'b0); reset = 1'b1;
      @(negedge axis_clk);
      chk("t5.beat1", 64'(m_tdata), 64'h61);
      next_cyc();
      drv0(1'b0, '0, 1'b0); reset = 1'b0;
      @(negedge axis_clk);
      chk("t5.rst.tvalid", 64'(m_tvalid), 64'd0);
      chk("t5.rst.tready", 64'({s0_tready, s1_tready}), 64'd0);
      chk("t5.rst.abort_cnt", 64'(abort_cnt), 64'd0);
      chk("t5.rst.busy", 64'(busy), 64'd0);
      next_cyc();
      got.delete(); gotl.delete(); i0 = 0;
      for (int c = 0; c < 20; c++) begin
         drv0(i0 < 2, (i0 == 0) ? 32'h71 : 32'h72, i0 == 1);
         @(negedge axis_clk);
         if (m_tvalid) begin
            got.push_back(m_tdata);
            gotl.push_back(m_tlast);
         end
         f0 = s0_tvalid & s0_tready;
         next_cyc();
         if (f0) i0++;
      end
      chk("t5.fresh.count", 64'(got.size()), 64'd2);
      if (got.size() == 2) begin
         chk("t5.fresh.d0", 64'({got[0], gotl[0]}), 64'({32'h71, 1'b0}));
         chk("t5.fresh.d1", 64'({got[1], gotl[1]}), 64'({32'h72, 1'b1}));
      end

      // test 6: zero-gap instance, two back-to-back 1-beat packets from s0
      got.delete(); i0 = 0;
      for (int c = 0; c < 8; c++) begin
         drvz(i0 < 2, (i0 == 0) ? 32'h31 : 32'h32, 1'b1);
         @(negedge axis_clk);
         zb[c] = z_busy;
         if (zm_tvalid) begin
            got.push_back(zm_tdata);
            zcyc.push_back(c);
         end
         f0 = z0_tvalid & z0_tready;
         next_cyc();
         if (f0) i0++;
      end
      drvz(1'b0, '0, 1'b0);
      chk("t6.count", 64'(got.size()), 64'd2);
      if (got.size() == 2) begin
         chk("t6.d0", 64'(got[0]), 64'h31);
         chk("t6.d1", 64'(got[1]), 64'h32);
         chk("t6.first_cyc", 64'(zcyc[0]), 64'd2);
         chk("t6.spacing", 64'(zcyc[1] - zcyc[0]), 64'd2);
      end
      chk("t6.busy_pattern", 64'({zb[0], zb[1], zb[2], zb[3], zb[4]}), 64'b01010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
